hazard_track_pipe: RTL and testbench
====================================

# hazard_track_pipe

Pipeline metadata tracker that feeds the hazard unit. Decodes the fetched instruction into hazard-relevant fields (opcode, rs1, rs2, rd, regwrite, wb_sel). Carries those fields through D/E/M/W slot registers under the hazard unit's stall/flush commands. Drives the hazard unit's register-index, regwrite, opcode and wb_sel inputs, and emits a retire pulse.

## Interface
- CNT_W, 32, width of performance counters
- i_clk  in  1  clock
- i_reset  in  1  reset; synchronous, active-high
- i_instr  in  32  instruction in IF
- i_if_valid  in  1  i_instr is a real instruction
- i_stallF, i_stallD  in  1  stall commands from hazard unit
- i_flushD, i_flushE, i_flushMEM  in  1  flush commands from hazard unit
- o_opcodeIF  out  7  i_instr[6:0], combinational
- o_opcodeEX  out  7  E-slot opcode
- o_rs1D, o_rs2D  out  5  D-slot sources
- o_rs1E, o_rs2E  out  5  E-slot sources
- o_ex_rd, o_mem_rd, o_wb_rd  out  5  destination of E/M/W slots
- o_ex_regwrite, o_mem_regwrite, o_wb_regwrite  out  1  regwrite of E/M/W slots
- o_wb_sel  out  2  E-slot wb_sel
- o_valid_vec  out  4  slot valid bits {W,M,E,D}
- o_retire  out  1  W slot holds a valid instruction
- o_cnt_stall, o_cnt_flush, o_cnt_retire  out  CNT_W  performance counters

## Operation
- Decode from i_instr:
  - opcode = [6:0], rd = [11:7], rs1 = [19:15], rs2 = [24:20].
  - regwrite = 1 for R (0110011), I-ALU (0010011), LOAD (0000011), LUI (0110111), AUIPC (0010111), JAL (1101111) and JALR (1100111). All other opcodes: regwrite = 0.
  - wb_sel = 00 for LOAD, 10 for JAL/JALR, 01 otherwise.
- Field masking:
  - rd forced to 0 when regwrite = 0.
  - rs2 forced to 0 unless opcode is R, STORE (0100011) or BRANCH (1100011).
  - rs1 forced to 0 for LUI, AUIPC and JAL.
- Bubble: valid = 0, opcode = 0010011, rs1 = rs2 = rd = 0, regwrite = 0, wb_sel = 01. Because wb_sel is never 00 in a bubble, a bubble can never trigger a load-use stall.
- Slot update at each edge, highest priority first:
  - D: i_flushD → bubble. Else i_stallD → hold. Else decoded i_instr if i_if_valid, otherwise bubble.
  - E: i_flushE or i_stallD → bubble. Else D.
  - M: i_flushMEM → bubble. Else E.
  - W: always M.
- Simultaneous stall and flush on the same slot: flush wins.
- i_stallF has no effect on the slots; it is used only by the counter.
- Outputs come straight from the slot registers, with no extra logic.

## Timing
- Reset: on a clock edge with i_reset = 1, all four slots become bubbles and all counters clear. This applies even in the middle of a stall or flush. Resulting output values:
  - o_valid_vec = 0000, o_retire = 0.
  - All rd/rs outputs = 0, all regwrite outputs = 0.
  - o_wb_sel = 01, o_opcodeEX = 0010011.
- Latency, for an instruction accepted at edge k with no stall or flush:
  - D outputs valid after edge k.
  - E after k+1, M after k+2, W after k+3.
  - o_retire is high for the one cycle following edge k+3.
- A stallD of n cycles holds D for n edges and inserts n E-bubbles.
- Counters wrap modulo 2^CNT_W.
- Counters increment at the edge when the condition holds during the preceding cycle:
  - o_cnt_stall: i_stallF = 1.
  - o_cnt_flush: i_flushE = 1 while i_stallD = 0.
  - o_cnt_retire: o_retire = 1.

## Configuration
- HAZARD_PERF_EN defined: the three counters are implemented as specified above.
- HAZARD_PERF_EN undefined: no counter registers are built, and the counter outputs are tied to 0. The ports remain present in both cases.

## Test plan
- Reset: assert i_reset for 1 edge with garbage in the slots → o_valid_vec = 0000, o_wb_sel = 01, o_opcodeEX = 0010011, every rd = 0.
- Straight line: addi x5,x0,5 (0x00500293) at edge 1 →
  - o_rs1D = 0 after edge 1.
  - o_ex_rd = 5 with o_ex_regwrite = 1 after edge 2.
  - o_mem_rd = 5 after edge 3.
  - o_wb_rd = 5 and o_retire = 1 after edge 4.
- Load-use: lw x6,0(x1) in E, add x7,x6,x2 in D. Assert i_stallD = i_flushE = 1 for 1 edge →
  - D still reports rs1D = 6.
  - E becomes a bubble (o_ex_rd = 0, o_wb_sel = 01).
  - o_mem_rd = 6.
- Branch flush: all slots valid. Assert i_flushD = i_flushE = i_flushMEM = 1 for 1 edge with i_if_valid = 1 → o_valid_vec = 1000, and W holds the former M instruction.
- Masking:
  - sw x7,0(x8) → o_ex_rd = 0, o_ex_regwrite = 0, rs1E = 8, rs2E = 7.
  - lui x9,1 → rs1 = rs2 = 0, rd = 9.
  - jal x1 → wb_sel = 10.
- Counters: 3 cycles with i_stallF = 1, then 5 retirements → with HAZARD_PERF_EN, o_cnt_stall = 3 and o_cnt_retire = 5; without it, both read 0.

Source files
------------

// File: rtl/hazard_track_pipe_if.sv
// Hazard-unit facing bundle for hazard_track_pipe: fetch input,
// stall/flush commands, slot metadata outputs and perf counters.
interface hazard_track_pipe_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      i_instr;
    logic             i_if_valid;
    logic             i_stallF;
    logic             i_stallD;
    logic             i_flushD;
    logic             i_flushE;
    logic             i_flushMEM;
    logic [6:0]       o_opcodeIF;
    logic [6:0]       o_opcodeEX;
    logic [4:0]       o_rs1D;
    logic [4:0]       o_rs2D;
    logic [4:0]       o_rs1E;
    logic [4:0]       o_rs2E;
    logic [4:0]       o_ex_rd;
    logic [4:0]       o_mem_rd;
    logic [4:0]       o_wb_rd;
    logic             o_ex_regwrite;
    logic             o_mem_regwrite;
    logic             o_wb_regwrite;
    logic [1:0]       o_wb_sel;
    logic [3:0]       o_valid_vec;
    logic             o_retire;
    logic [CNT_W-1:0] o_cnt_stall;
    logic [CNT_W-1:0] o_cnt_flush;
    logic [CNT_W-1:0] o_cnt_retire;

    modport master (
        output i_instr, i_if_valid, i_stallF, i_stallD,
        output i_flushD, i_flushE, i_flushMEM,
        input  o_opcodeIF, o_opcodeEX, o_rs1D, o_rs2D, o_rs1E, o_rs2E,
        input  o_ex_rd, o_mem_rd, o_wb_rd,
        input  o_ex_regwrite, o_mem_regwrite, o_wb_regwrite,
        input  o_wb_sel, o_valid_vec, o_retire,
        input  o_cnt_stall, o_cnt_flush, o_cnt_retire
    );

    modport slave (
        input  i_instr, i_if_valid, i_stallF, i_stallD,
        input  i_flushD, i_flushE, i_flushMEM,
        output o_opcodeIF, o_opcodeEX, o_rs1D, o_rs2D, o_rs1E, o_rs2E,
        output o_ex_rd, o_mem_rd, o_wb_rd,
        output o_ex_regwrite, o_mem_regwrite, o_wb_regwrite,
        output o_wb_sel, o_valid_vec, o_retire,
        output o_cnt_stall, o_cnt_flush, o_cnt_retire
    );
endinterface

// File: rtl/hazard_track_pipe.sv
// D/E/M/W hazard metadata tracker with retire pulse.
// Define HAZARD_PERF_EN to build the stall/flush/retire counters.
module hazard_track_pipe #(
    parameter int CNT_W = 32
) (
    input logic          i_clk,
    input logic          i_reset,
    hazard_track_pipe_if.slave hz
);
    typedef struct packed {
        logic       valid;
        logic [6:0] opcode;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       regwrite;
        logic [1:0] wb_sel;
    } slot_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;

    // wb_sel of 01 keeps a bubble from ever looking like a load
    localparam slot_t BUBBLE = '{
        valid: 1'b0, opcode: OP_IMM, rs1: 5'd0, rs2: 5'd0,
        rd: 5'd0, regwrite: 1'b0, wb_sel: 2'b01
    };

    slot_t      dec;
    slot_t      d_q;
    slot_t      e_q;
    slot_t      m_q;
    slot_t      w_q;
    logic [6:0] op;
    logic       rw;
    logic       use_rs1;
    logic       use_rs2;
    logic [1:0] wb;
    logic       unused_instr;

    assign op           = hz.i_instr[6:0];
    assign unused_instr = ^{hz.i_instr[31:25], hz.i_instr[14:12]};

    always_comb begin
        rw      = 1'b0;
        use_rs1 = 1'b1;
        use_rs2 = 1'b0;
        wb      = 2'b01;
        case (op)
            OP_R:     begin rw = 1'b1; use_rs2 = 1'b1; end
            OP_IMM:   rw = 1'b1;
            OP_LOAD:  begin rw = 1'b1; wb = 2'b00; end
            OP_LUI:   begin rw = 1'b1; use_rs1 = 1'b0; end
            OP_AUIPC: begin rw = 1'b1; use_rs1 = 1'b0; end
            OP_JAL:   begin rw = 1'b1; use_rs1 = 1'b0; wb = 2'b10; end
            OP_JALR:  begin rw = 1'b1; wb = 2'b10; end
            OP_STORE: use_rs2 = 1'b1;
            OP_BR:    use_rs2 = 1'b1;
            default:  ;
        endcase
        dec.valid    = 1'b1;
        dec.opcode   = op;
        dec.rd       = rw ? hz.i_instr[11:7] : 5'd0;
        dec.rs1      = use_rs1 ? hz.i_instr[19:15] : 5'd0;
        dec.rs2      = use_rs2 ? hz.i_instr[24:20] : 5'd0;
        dec.regwrite = rw;
        dec.wb_sel   = wb;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            d_q <= BUBBLE;
            e_q <= BUBBLE;
            m_q <= BUBBLE;
            w_q <= BUBBLE;
        end else begin
            if (hz.i_flushD)
                d_q <= BUBBLE;
            else if (!hz.i_stallD)
                d_q <= hz.i_if_valid ? dec : BUBBLE;
            e_q <= (hz.i_flushE || hz.i_stallD) ? BUBBLE : d_q;
            m_q <= hz.i_flushMEM ? BUBBLE : e_q;
            w_q <= m_q;
        end
    end

    assign hz.o_opcodeIF     = op;
    assign hz.o_opcodeEX     = e_q.opcode;
    assign hz.o_rs1D         = d_q.rs1;
    assign hz.o_rs2D         = d_q.rs2;
    assign hz.o_rs1E         = e_q.rs1;
    assign hz.o_rs2E         = e_q.rs2;
    assign hz.o_ex_rd        = e_q.rd;
    assign hz.o_mem_rd       = m_q.rd;
    assign hz.o_wb_rd        = w_q.rd;
    assign hz.o_ex_regwrite  = e_q.regwrite;
    assign hz.o_mem_regwrite = m_q.regwrite;
    assign hz.o_wb_regwrite  = w_q.regwrite;
    assign hz.o_wb_sel       = e_q.wb_sel;
    assign hz.o_valid_vec    = {w_q.valid, m_q.valid, e_q.valid, d_q.valid};
    assign hz.o_retire       = w_q.valid;

`ifdef HAZARD_PERF_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_stall;
    logic [CNT_W-1:0] cnt_flush;
    logic [CNT_W-1:0] cnt_retire;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_stall  <= '0;
            cnt_flush  <= '0;
            cnt_retire <= '0;
        end else begin
            if (hz.i_stallF)
                cnt_stall <= cnt_stall + CNT_ONE;
            // a flushE under stallD is a load-use bubble, not a redirect
            if (hz.i_flushE && !hz.i_stallD)
                cnt_flush <= cnt_flush + CNT_ONE;
            if (w_q.valid)
                cnt_retire <= cnt_retire + CNT_ONE;
        end
    end

    assign hz.o_cnt_stall  = cnt_stall;
    assign hz.o_cnt_flush  = cnt_flush;
    assign hz.o_cnt_retire = cnt_retire;
`else
    logic unused_perf;

    assign unused_perf     = hz.i_stallF;
    assign hz.o_cnt_stall  = '0;
    assign hz.o_cnt_flush  = '0;
    assign hz.o_cnt_retire = '0;
`endif
endmodule

// File: tb/tb_hazard_track_pipe.sv
// Scoreboard bench for hazard_track_pipe: stimulus queues timed
// expectations, a negedge monitor pops and compares them.
module tb_hazard_track_pipe;
  localparam logic [31:0] ADDI = 32'h00500293;
  localparam logic [31:0] LW   = 32'h0000A303;
  localparam logic [31:0] ADD  = 32'h002303B3;
  localparam logic [31:0] SW   = 32'h00742223;
  localparam logic [31:0] LUI  = 32'h123454B7;
  localparam logic [31:0] JAL  = 32'h000000EF;

`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam int F_VALID  = 0;
  localparam int F_RS1D   = 1;
  localparam int F_RS2D   = 2;
  localparam int F_RS1E   = 3;
  localparam int F_RS2E   = 4;
  localparam int F_EXRD   = 5;
  localparam int F_MEMRD  = 6;
  localparam int F_WBRD   = 7;
  localparam int F_EXRW   = 8;
  localparam int F_WBRW   = 9;
  localparam int F_WBSEL  = 10;
  localparam int F_OPEX   = 11;
  localparam int F_OPIF   = 12;
  localparam int F_RET    = 13;
  localparam int F_CSTALL = 14;
  localparam int F_CFLUSH = 15;
  localparam int F_CRET   = 16;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] val;
    string       name;
  } chk_t;

  logic clk;
  logic rst;
  int   ecnt;
  int   nchk;
  int   nfail;
  chk_t q[$];

  hazard_track_pipe_if #(.CNT_W(32)) hz ();

  hazard_track_pipe #(.CNT_W(32)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .hz      (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial ecnt = 0;
  always @(posedge clk) ecnt <= ecnt + 1;

  function automatic logic [31:0] field(input int sel);
    logic [31:0] r;
    r = '0;
    case (sel)
      F_VALID:  r = 32'(hz.o_valid_vec);
      F_RS1D:   r = 32'(hz.o_rs1D);
      F_RS2D:   r = 32'(hz.o_rs2D);
      F_RS1E:   r = 32'(hz.o_rs1E);
      F_RS2E:   r = 32'(hz.o_rs2E);
      F_EXRD:   r = 32'(hz.o_ex_rd);
      F_MEMRD:  r = 32'(hz.o_mem_rd);
      F_WBRD:   r = 32'(hz.o_wb_rd);
      F_EXRW:   r = 32'(hz.o_ex_regwrite);
      F_WBRW:   r = 32'(hz.o_wb_regwrite);
      F_WBSEL:  r = 32'(hz.o_wb_sel);
      F_OPEX:   r = 32'(hz.o_opcodeEX);
      F_OPIF:   r = 32'(hz.o_opcodeIF);
      F_RET:    r = 32'(hz.o_retire);
      F_CSTALL: r = hz.o_cnt_stall;
      F_CFLUSH: r = hz.o_cnt_flush;
      F_CRET:   r = hz.o_cnt_retire;
      default:  r = 32'hDEAD_BEEF;
    endcase
    return r;
  endfunction

  always @(negedge clk) begin
    logic [31:0] got;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc <= ecnt) begin
        got = field(q[i].sel);
        nchk++;
        if (got !== q[i].val) begin
          nfail++;
          $display("FAIL %s after edge %0d: got %0h expected %0h",
                   q[i].name, ecnt, got, q[i].val);
        end
        q.delete(i);
      end
    end
  end

  task automatic expect_at(input int off, input int sel,
                           input logic [31:0] val, input string nm);
    chk_t c;
    c.cyc  = ecnt + off;
    c.sel  = sel;
    c.val  = val;
    c.name = nm;
    q.push_back(c);
  endtask

  task automatic issue(input logic [31:0] ins, input logic v,
                       input logic sf, input logic sd,
                       input logic fd, input logic fe,
                       input logic fm, input logic r);
    hz.i_instr    = ins;
    hz.i_if_valid = v;
    hz.i_stallF   = sf;
    hz.i_stallD   = sd;
    hz.i_flushD   = fd;
    hz.i_flushE   = fe;
    hz.i_flushMEM = fm;
    rst           = r;
    @(posedge clk);
    #1;
  endtask

  task automatic bubble(input int n);
    for (int i = 0; i < n; i++)
      issue(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic feed(input logic [31:0] ins);
    issue(ins, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    nchk  = 0;
    nfail = 0;
    hz.i_instr    = '0;
    hz.i_if_valid = 1'b0;
    hz.i_stallF   = 1'b0;
    hz.i_stallD   = 1'b0;
    hz.i_flushD   = 1'b0;
    hz.i_flushE   = 1'b0;
    hz.i_flushMEM = 1'b0;
    rst           = 1'b1;

    issue(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    issue(LW, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(ADD, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(JAL, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_at(1, F_VALID, 32'h0, "rst_valid");
    expect_at(1, F_WBSEL, 32'h1, "rst_wbsel");
    expect_at(1, F_OPEX, 32'h13, "rst_opex");
    expect_at(1, F_EXRD, 32'h0, "rst_exrd");
    expect_at(1, F_MEMRD, 32'h0, "rst_memrd");
    expect_at(1, F_WBRD, 32'h0, "rst_wbrd");
    expect_at(1, F_EXRW, 32'h0, "rst_exrw");
    expect_at(1, F_RET, 32'h0, "rst_retire");
    expect_at(1, F_CSTALL, 32'h0, "rst_cstall");
    issue(SW, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);

    nchk++;
    if (hz.o_valid_vec !== 4'b0000) begin
      nfail++;
      $display("FAIL d_rst_valid: got %0h", hz.o_valid_vec);
    end
    nchk++;
    if (hz.o_wb_sel !== 2'b01) begin
      nfail++;
      $display("FAIL d_rst_wbsel: got %0h", hz.o_wb_sel);
    end
    nchk++;
    if (hz.o_opcodeEX !== 7'b0010011) begin
      nfail++;
      $display("FAIL d_rst_opex: got %0h", hz.o_opcodeEX);
    end
    nchk++;
    if (hz.o_ex_rd !== 5'd0) begin
      nfail++;
      $display("FAIL d_rst_exrd: got %0h", hz.o_ex_rd);
    end
    nchk++;
    if (hz.o_retire !== 1'b0) begin
      nfail++;
      $display("FAIL d_rst_retire: got %0h", hz.o_retire);
    end

    expect_at(1, F_VALID, 32'h1, "sl_valid_d");
    expect_at(1, F_RS1D, 32'h0, "sl_rs1d");
    expect_at(2, F_EXRD, 32'h5, "sl_exrd");
    expect_at(2, F_EXRW, 32'h1, "sl_exrw");
    expect_at(3, F_MEMRD, 32'h5, "sl_memrd");
    expect_at(4, F_WBRD, 32'h5, "sl_wbrd");
    expect_at(4, F_RET, 32'h1, "sl_retire");
    expect_at(5, F_RET, 32'h0, "sl_retire_end");
    feed(ADDI);
    bubble(4);

    feed(LW);
    expect_at(1, F_EXRD, 32'h6, "lu_ex_lw");
    expect_at(1, F_WBSEL, 32'h0, "lu_wbsel_load");
    expect_at(1, F_RS1D, 32'h6, "lu_rs1d");
    expect_at(1, F_RS2D, 32'h2, "lu_rs2d");
    feed(ADD);
    expect_at(1, F_RS1D, 32'h6, "lu_hold_rs1d");
    expect_at(1, F_EXRD, 32'h0, "lu_bub_exrd");
    expect_at(1, F_WBSEL, 32'h1, "lu_bub_wbsel");
    expect_at(1, F_MEMRD, 32'h6, "lu_memrd");
    expect_at(1, F_VALID, 32'h5, "lu_valid");
    issue(SW, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_at(1, F_EXRD, 32'h7, "lu_rel_exrd");
    expect_at(1, F_RS1E, 32'h6, "lu_rel_rs1e");
    expect_at(1, F_RS2E, 32'h2, "lu_rel_rs2e");
    expect_at(1, F_VALID, 32'hA, "lu_rel_valid");
    bubble(4);

    feed(ADDI);
    feed(LW);
    feed(ADD);
    expect_at(1, F_VALID, 32'hF, "bf_full");
    feed(JAL);
    expect_at(1, F_VALID, 32'h8, "bf_valid");
    expect_at(1, F_WBRD, 32'h6, "bf_wbrd");
    expect_at(1, F_WBRW, 32'h1, "bf_wbrw");
    expect_at(1, F_CFLUSH, PERF ? 32'h1 : 32'h0, "bf_cflush");
    issue(LUI, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    expect_at(1, F_VALID, 32'h1, "bf_refill");
    feed(ADDI);
    expect_at(1, F_VALID, 32'h0, "flush_beats_stall");
    issue(ADDI, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    bubble(3);

    expect_at(0, F_OPIF, 32'h23, "opif_sw");
    expect_at(2, F_EXRD, 32'h0, "sw_exrd");
    expect_at(2, F_EXRW, 32'h0, "sw_exrw");
    expect_at(2, F_RS1E, 32'h8, "sw_rs1e");
    expect_at(2, F_RS2E, 32'h7, "sw_rs2e");
    feed(SW);
    expect_at(1, F_RS1D, 32'h0, "lui_rs1d");
    expect_at(1, F_RS2D, 32'h0, "lui_rs2d");
    expect_at(2, F_EXRD, 32'h9, "lui_exrd");
    expect_at(2, F_RS1E, 32'h0, "lui_rs1e");
    feed(LUI);
    expect_at(2, F_WBSEL, 32'h2, "jal_wbsel");
    expect_at(2, F_EXRD, 32'h1, "jal_exrd");
    expect_at(2, F_OPEX, 32'h6F, "jal_opex");
    feed(JAL);
    bubble(4);

    issue(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)
      issue(32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)
      feed(ADDI);
    bubble(4);
    expect_at(1, F_CSTALL, PERF ? 32'd3 : 32'd0, "cnt_stall");
    expect_at(1, F_CRET, PERF ? 32'd5 : 32'd0, "cnt_retire");
    expect_at(1, F_CFLUSH, 32'd0, "cnt_flush");
    bubble(1);

    nchk++;
    if (hz.o_cnt_stall !== (PERF ? 32'd3 : 32'd0)) begin
      nfail++;
      $display("FAIL d_cnt_stall: got %0d", hz.o_cnt_stall);
    end
    nchk++;
    if (hz.o_cnt_retire !== (PERF ? 32'd5 : 32'd0)) begin
      nfail++;
      $display("FAIL d_cnt_retire: got %0d", hz.o_cnt_retire);
    end

    bubble(3);
    foreach (q[i]) begin
      nchk++;
      nfail++;
      $display("FAIL %s: never checked, expected %0h", q[i].name, q[i].val);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
